// File: rtl/des_round_ctrl.sv
// Sequencer for the DES round datapath: load strobe, NUM_ROUNDS round enables, output latch, result handshake.
// Optional decrypt ordering (descending round index, right key rotation) under `DES_ROUND_CTRL_DECRYPT_EN.
module des_round_ctrl #(
    parameter int NUM_ROUNDS = 16,
    parameter int IDX_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             abort,
`ifdef DES_ROUND_CTRL_DECRYPT_EN
    input  logic             decrypt,
    output logic             key_rot_right,
`endif
    output logic             load_init,
    output logic             round_en,
    output logic [IDX_W-1:0] round_idx,
    output logic [1:0]       shift_amt,
    output logic             out_latch,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    typedef enum logic [2:0] {IDLE, LOAD, ROUND, FINAL, DONE} state_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_ROUNDS - 1);

    state_t           state, state_n;
    logic [IDX_W-1:0] cnt;
    logic             last;

    assign last = (cnt == LAST);

    // DES key schedule: single-bit rotation in rounds 0, 1, 8 and 15, double elsewhere.
    function automatic logic [1:0] enc_amt(input int unsigned i);
        return (i == 0 || i == 1 || i == 8 || i == 15) ? 2'd1 : 2'd2;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            // Counter is only non-zero while rounds are in flight.
            cnt   <= (abort || state != ROUND || last) ? '0 : cnt + IDX_W'(1);
        end
    end

`ifdef DES_ROUND_CTRL_DECRYPT_EN
    logic dec_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            dec_q <= 1'b0;
        else if (state == IDLE && in_valid && !abort)
            dec_q <= decrypt;
    end
`endif

    always_comb begin
        state_n = state;
        if (abort) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE:    if (in_valid) state_n = LOAD;
                LOAD:    state_n = ROUND;
                ROUND:   if (last) state_n = FINAL;
                FINAL:   state_n = DONE;
                DONE:    if (out_ready) state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state == IDLE);
        busy      = (state != IDLE);
        load_init = (state == LOAD);
        round_en  = (state == ROUND);
        out_latch = (state == FINAL);
        out_valid = (state == DONE);
        round_idx = '0;
        shift_amt = 2'd0;
`ifdef DES_ROUND_CTRL_DECRYPT_EN
        key_rot_right = 1'b0;
`endif
        if (state == ROUND) begin
            round_idx = cnt;
            shift_amt = enc_amt(int'(cnt));
`ifdef DES_ROUND_CTRL_DECRYPT_EN
            // Decrypt walks the schedule backwards; each round undoes the rotation of the next encrypt round.
            if (dec_q) begin
                key_rot_right = 1'b1;
                round_idx     = LAST - cnt;
                shift_amt     = (cnt == '0) ? 2'd0 : enc_amt(int'(LAST - cnt) + 1);
            end
`endif
        end
    end

endmodule

// File: tb/tb_des_round_ctrl.sv
// Scoreboard bench for des_round_ctrl: stimulus pushes expected strobe events, a negedge monitor pops and compares.
module tb_des_round_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, abort;
    logic       load_init, round_en, out_latch, out_valid, out_ready, busy;
    logic [3:0] round_idx;
    logic [1:0] shift_amt;
    logic       krr_w;
`ifdef DES_ROUND_CTRL_DECRYPT_EN
    logic       decrypt = 1'b0;
    logic       key_rot_right;
    assign krr_w = key_rot_right;
`else
    assign krr_w = 1'b0;
`endif

    des_round_ctrl #(.NUM_ROUNDS(16), .IDX_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .abort(abort),
`ifdef DES_ROUND_CTRL_DECRYPT_EN
        .decrypt(decrypt), .key_rot_right(key_rot_right),
`endif
        .load_init(load_init), .round_en(round_en), .round_idx(round_idx), .shift_amt(shift_amt),
        .out_latch(out_latch), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic       ld, re, ol, ov, krr;
        logic [3:0] idx;
        logic [1:0] sh;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    logic prev_ov = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input int c, input logic ld, re, ol, ov, krr, input int idx, input int sh);
        exp_t e;
        e.cyc = c; e.ld = ld; e.re = re; e.ol = ol; e.ov = ov; e.krr = krr;
        e.idx = 4'(idx); e.sh = 2'(sh);
        return e;
    endfunction

    // Hand-written rotation tables, indexed by position within the block.
    task automatic push_block(input int a, input bit dec);
        int enc_sh[16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
        int dec_sh[16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
        sb.push_back(mk(a, 1, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 16; k++)
            sb.push_back(mk(a + 1 + k, 0, 1, 0, 0, dec, dec ? 15 - k : k, dec ? dec_sh[k] : enc_sh[k]));
        sb.push_back(mk(a + 17, 0, 0, 1, 0, 0, 0, 0));
        sb.push_back(mk(a + 18, 0, 0, 0, 1, 0, 0, 0));
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_ov = 1'b0;
        end else begin
            chk("strobe_onehot", 32'($countones({load_init, round_en, out_latch}) <= 1), 1);
            chk("busy_vs_in_ready", busy, !in_ready);
            if (load_init || round_en || out_latch || (out_valid && !prev_ov)) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event cyc=%0d ld=%b re=%b idx=%0d ol=%b ov=%b expected no event",
                             cyc, load_init, round_en, round_idx, out_latch, out_valid);
                end else begin
                    mon_e = sb.pop_front();
                    chk("event_cycle", cyc, mon_e.cyc);
                    chk("load_init", load_init, mon_e.ld);
                    chk("round_en", round_en, mon_e.re);
                    chk("round_idx", round_idx, mon_e.idx);
                    chk("shift_amt", shift_amt, mon_e.sh);
                    chk("out_latch", out_latch, mon_e.ol);
                    chk("out_valid", out_valid, mon_e.ov);
                    chk("key_rot_right", krr_w, mon_e.krr);
                end
            end
            prev_ov = out_valid;
        end
    end

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_in_ready"}, in_ready, 1);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_strobes"}, {load_init, round_en, out_latch, out_valid}, 0);
        chk({nm, "_idx_sh"}, {round_idx, shift_amt}, 0);
        chk({nm, "_krr"}, krr_w, 0);
    endtask

    task automatic start_block(input bit dec);
        int a;
        @(negedge clk);
        chk("in_ready_before_start", in_ready, 1);
        in_valid = 1'b1;
`ifdef DES_ROUND_CTRL_DECRYPT_EN
        decrypt = dec;
`endif
        @(posedge clk); #1;
        a = cyc;
        in_valid = 1'b0;
        push_block(a, dec);
    endtask

    task automatic wait_valid();
        int i;
        for (i = 0; i < 60; i++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        checks++;
        if (i == 60) begin
            errors++;
            $display("FAIL wait_out_valid actual=timeout required=out_valid within 60 cycles");
        end
    endtask

    task automatic wait_idx(input int v);
        int i;
        for (i = 0; i < 40; i++) begin
            @(negedge clk);
            if (round_en && round_idx == 4'(v)) break;
        end
        checks++;
        if (i == 40) begin
            errors++;
            $display("FAIL wait_round_idx actual=timeout required=round_idx %0d", v);
        end
    endtask

    task automatic finish_block();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("handshake_in_ready", in_ready, 1);
        chk("handshake_out_valid", out_valid, 0);
    endtask

    initial begin
        int a;
        rst = 1'b1; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b0;
        #3;
        chk_reset_vals("reset");
        #17;
        rst = 1'b0;

        // Full encrypt block, then DONE held against a stalled consumer.
        start_block(0);
        wait_valid();
        repeat (10) begin
            @(negedge clk);
            chk("done_hold_out_valid", out_valid, 1);
            chk("done_hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        chk("release_in_ready", in_ready, 1);
        chk("release_out_valid", out_valid, 0);
        out_ready = 1'b0;
        @(posedge clk); #1;
        a = cyc;
        in_valid = 1'b0;
        push_block(a, 0);
        chk("b2b_accepted", load_init, 1);
        wait_valid();
        finish_block();

        // Abort mid-round.
        start_block(0);
        wait_idx(5);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("abort_round_en", round_en, 0);
        chk("abort_round_idx", round_idx, 0);
        chk("abort_in_ready", in_ready, 1);

        // Abort wins over in_valid in IDLE.
        abort = 1'b1; in_valid = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("abort_idle_no_load", load_init, 0);
            chk("abort_idle_in_ready", in_ready, 1);
        end
        @(negedge clk);
        abort = 1'b0; in_valid = 1'b0;

        // Abort in DONE drops out_valid without a handshake.
        start_block(0);
        wait_valid();
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_done_out_valid", out_valid, 0);
        chk("abort_done_in_ready", in_ready, 1);

        // Asynchronous reset mid-cycle.
        start_block(0);
        wait_idx(9);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_vals("async_rst");
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        start_block(0);
        wait_valid();
        finish_block();

`ifdef DES_ROUND_CTRL_DECRYPT_EN
        start_block(1);
        wait_valid();
        finish_block();
        start_block(0);
        wait_valid();
        finish_block();
`endif

        @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=still running required=finish");
        $fatal(1, "timeout");
    end

endmodule
